sar_adc_multi: RTL and testbench

Parametrised successor to the team's single-channel 7-bit ADC block: a multi-channel successive-approximation (SAR) conversion controller with a start/busy/valid handshake. It selects one of CHANNELS digitised analog words, samples it, and resolves it MSB-first against an internal DAC trial word over WIDTH cycles. It publishes the result with a trustbit that flags whether the input stayed stable during conversion. It sits between the analog front-end model and downstream consumers of ADC samples.

---
 rtl/adc_pkg.sv | 20 ++
 rtl/sar_adc_multi_if.sv | 31 +++
 rtl/adc_chan_mux.sv | 29 ++
 rtl/sar_adc_multi.sv | 159 +++++++++++++++
 tb/tb_sar_adc_multi.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and defaults for the SAR conversion controller
// Ports: none (package).
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } adc_state_e;

  localparam int DEF_WIDTH    = 7;
  localparam int DEF_CHANNELS = 4;

  // Channel-select width; a single-channel build still carries a 1-bit select.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_adc_multi_if.sv
// rtl/sar_adc_multi_if.sv - request/result handshake bundle of the SAR controller
// Signals:
//   start, abort, chan_sel         requester -> converter
//   busy, valid, dout, trustbit,   converter -> requester
//   chan_out
// Modports: master (requester side), slave (converter side).
interface sar_adc_multi_if #(
  parameter int WIDTH = adc_pkg::DEF_WIDTH,
  parameter int CW    = adc_pkg::chan_width(adc_pkg::DEF_CHANNELS)
);

  logic             start;
  logic             abort;
  logic [CW-1:0]    chan_sel;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] dout;
  logic             trustbit;
  logic [CW-1:0]    chan_out;

  modport master (
    output start, abort, chan_sel,
    input  busy, valid, dout, trustbit, chan_out
  );

  modport slave (
    input  start, abort, chan_sel,
    output busy, valid, dout, trustbit, chan_out
  );

endinterface

// File: rtl/adc_chan_mux.sv
// rtl/adc_chan_mux.sv - combinational channel selector over the packed analog bus
// Ports:
//   analog_in  in   CHANNELS*WIDTH  channel c at [c*WIDTH +: WIDTH]
//   chan       in   CW              channel to select
//   word       out  WIDTH           selected word, 0 when chan is out of range
//   legal      out  1               chan < CHANNELS
module adc_chan_mux #(
  parameter int WIDTH    = 7,
  parameter int CHANNELS = 4,
  parameter int CW       = 2
) (
  input  logic [CHANNELS*WIDTH-1:0] analog_in,
  input  logic [CW-1:0]             chan,
  output logic [WIDTH-1:0]          word,
  output logic                      legal
);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (chan == CW'(c)) begin
        word  = analog_in[c*WIDTH +: WIDTH];
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_adc_multi.sv
// rtl/sar_adc_multi.sv - multi-channel successive-approximation conversion controller
// Ports:
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   ctrl       slave modport        start/abort/chan_sel in; busy/valid/dout/trustbit/chan_out out
//   analog_in  in   CHANNELS*WIDTH  digitised analog words, channel c at [c*WIDTH +: WIDTH]
//   dac_out    out  WIDTH           current trial word
module sar_adc_multi import adc_pkg::*; #(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int CHANNELS = DEF_CHANNELS,
  localparam int CW       = chan_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  sar_adc_multi_if.slave            ctrl,
  input  logic [CHANNELS*WIDTH-1:0] analog_in,
  output logic [WIDTH-1:0]          dac_out
);

  localparam int               IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]    TOP_IDX = IW'(WIDTH - 1);

  adc_state_e       state_q, state_d;
  logic [CW-1:0]    chan_q, chan_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             trust_q, trust_d;
  logic [CW-1:0]    chan_out_q, chan_out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] mux_word;
  logic             mux_legal;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] resolved;

  // One selector serves both the sample capture and the end-of-conversion
  // stability recheck, since both look at the channel latched at start.
  adc_chan_mux #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_mux (
    .analog_in (analog_in),
    .chan      (chan_q),
    .word      (mux_word),
    .legal     (mux_legal)
  );

  // bit_mask marks the bit under test; the trial keeps it only if the
  // sampled word is at or above the trial value.
  assign bit_mask = ONE_W << idx_q;
  assign resolved = (sample_q >= trial_q) ? trial_q : (trial_q & ~bit_mask);

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    sample_d   = sample_q;
    trial_d    = trial_q;
    idx_d      = idx_q;
    dout_d     = dout_q;
    trust_d    = trust_q;
    chan_out_d = chan_out_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          chan_d  = ctrl.chan_sel;
          busy_d  = 1'b1;
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        if (ctrl.abort) begin
          busy_d  = 1'b0;
          trial_d = '0;
          state_d = IDLE;
        end else begin
          sample_d = mux_word;
          trial_d  = MSB_BIT;
          idx_d    = TOP_IDX;
          state_d  = CONVERT;
        end
      end

      CONVERT: begin
        if (ctrl.abort) begin
          busy_d  = 1'b0;
          trial_d = '0;
          state_d = IDLE;
        end else if (idx_q != '0) begin
          trial_d = resolved | (bit_mask >> 1);
          idx_d   = idx_q - IW'(1);
        end else begin
          trial_d    = resolved;
          dout_d     = resolved;
          chan_out_d = chan_q;
          valid_d    = 1'b1;
          // Trust only if the selected input still matches what was sampled.
          trust_d    = (mux_word == sample_q) && mux_legal;
          state_d    = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        trial_d = '0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        trial_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      sample_q   <= '0;
      trial_q    <= '0;
      idx_q      <= '0;
      dout_q     <= '0;
      trust_q    <= 1'b0;
      chan_out_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      sample_q   <= sample_d;
      trial_q    <= trial_d;
      idx_q      <= idx_d;
      dout_q     <= dout_d;
      trust_q    <= trust_d;
      chan_out_q <= chan_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign dac_out       = trial_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.valid    = valid_q;
  assign ctrl.dout     = dout_q;
  assign ctrl.trustbit = trust_q;
  assign ctrl.chan_out = chan_out_q;

endmodule

// File: tb/tb_sar_adc_multi.sv
// tb/tb_sar_adc_multi.sv - directed bench for sar_adc_multi (4-channel and 3-channel builds)
module tb_sar_adc_multi;
  import adc_pkg::*;

  localparam int W  = 7;
  localparam int CA = 4;
  localparam int CB = 3;
  localparam int CWA = 2;
  localparam int CWB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CA*W-1:0] ana_a;
  logic [CB*W-1:0] ana_b;
  logic [W-1:0]    dac_a;
  logic [W-1:0]    dac_b;

  sar_adc_multi_if #(.WIDTH(W), .CW(CWA)) if_a ();
  sar_adc_multi_if #(.WIDTH(W), .CW(CWB)) if_b ();

  sar_adc_multi #(.WIDTH(W), .CHANNELS(CA)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl      (if_a),
    .analog_in (ana_a),
    .dac_out   (dac_a)
  );

  sar_adc_multi #(.WIDTH(W), .CHANNELS(CB)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctrl      (if_b),
    .analog_in (ana_b),
    .dac_out   (dac_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] dac_log [0:20];
  logic [W-1:0] exp_dac [0:6];

  typedef struct {
    bit         use_b;
    logic [1:0] chan;
    logic [6:0] exp_dout;
    logic       exp_trust;
    logic [1:0] exp_chout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start a conversion at a falling edge and watch falling edges until valid.
  // lat counts falling edges after the one that raised start.
  task automatic run_conv(input bit use_b, input logic [1:0] chan,
                          input int chg_at, input logic [6:0] chg_val,
                          output int lat, output logic [6:0] d, output logic t,
                          output logic [1:0] co, output logic v_after,
                          output logic busy_after);
    lat = -1; d = '0; t = 1'b0; co = '0; v_after = 1'b1; busy_after = 1'b1;
    @(negedge clk);
    if (use_b) begin
      if_b.chan_sel = chan; if_b.start = 1'b1;
    end else begin
      if_a.chan_sel = chan; if_a.start = 1'b1;
    end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) begin
        if_a.start = 1'b0;
        if_b.start = 1'b0;
      end
      if (j == chg_at) ana_a[chan*W +: W] = chg_val;
      dac_log[j] = use_b ? dac_b : dac_a;
      if (lat < 0 && (use_b ? if_b.valid : if_a.valid)) begin
        lat = j;
        d   = use_b ? if_b.dout : if_a.dout;
        t   = use_b ? if_b.trustbit : if_a.trustbit;
        co  = use_b ? if_b.chan_out : if_a.chan_out;
      end else if (lat >= 0) begin
        v_after    = use_b ? if_b.valid : if_a.valid;
        busy_after = use_b ? if_b.busy : if_a.busy;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    logic [6:0] d;
    logic       t;
    logic [1:0] co;
    logic       va;
    logic       ba;
    int         seen_valid;
    int         seen_busy;

    exp_dac = '{7'h40, 7'h20, 7'h10, 7'h18, 7'h14, 7'h12, 7'h11};

    vecs[0] = '{1'b0, 2'd0, 7'h10, 1'b1, 2'd0};
    vecs[1] = '{1'b0, 2'd1, 7'h00, 1'b1, 2'd1};
    vecs[2] = '{1'b0, 2'd2, 7'h7F, 1'b1, 2'd2};
    vecs[3] = '{1'b0, 2'd3, 7'h03, 1'b1, 2'd3};
    vecs[4] = '{1'b1, 2'd1, 7'h55, 1'b1, 2'd1};
    vecs[5] = '{1'b1, 2'd3, 7'h00, 1'b0, 2'd3};
    vecs[6] = '{1'b1, 2'd2, 7'h01, 1'b1, 2'd2};

    if_a.start = 1'b0; if_a.abort = 1'b0; if_a.chan_sel = '0;
    if_b.start = 1'b0; if_b.abort = 1'b0; if_b.chan_sel = '0;
    ana_a = {7'h03, 7'h7F, 7'h00, 7'h10};
    ana_b = {7'h01, 7'h55, 7'h2A};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs_a", {if_a.busy, if_a.valid, if_a.trustbit, if_a.dout, if_a.chan_out, dac_a}, 32'h0);
    check("reset_outputs_b", {if_b.busy, if_b.valid, if_b.trustbit, if_b.dout, if_b.chan_out, dac_b}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven conversions on both builds
    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].use_b, vecs[i].chan, 0, 7'h00, lat, d, t, co, va, ba);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_dout", i), d, vecs[i].exp_dout);
      check($sformatf("v%0d_trust", i), t, vecs[i].exp_trust);
      check($sformatf("v%0d_chan_out", i), co, vecs[i].exp_chout);
      check($sformatf("v%0d_valid_one_cycle", i), va, 0);
      check($sformatf("v%0d_busy_drop", i), ba, 0);
      if (i == 0) begin
        for (int k = 0; k < 7; k++)
          check($sformatf("dac_seq_%0d", k), dac_log[k+2], exp_dac[k]);
        check("dac_done_value", dac_log[9], 7'h10);
      end
    end

    // Input moves 0x10 -> 0x1F during CONVERT: result follows the sample, trust drops
    run_conv(1'b0, 2'd0, 3, 7'h1F, lat, d, t, co, va, ba);
    check("unstable_latency", lat, 9);
    check("unstable_dout", d, 7'h10);
    check("unstable_trust", t, 0);

    // Abort in 3rd CONVERT cycle with a start pulse issued while busy
    @(negedge clk);
    if_a.chan_sel = 2'd2; if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    @(negedge clk);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    @(negedge clk);
    check("abort_dac_before", dac_a, 7'h70);
    check("abort_busy_before", if_a.busy, 1);
    if_a.abort = 1'b1;
    @(negedge clk);
    if_a.abort = 1'b0;
    check("abort_busy_after", if_a.busy, 0);
    check("abort_dac_after", dac_a, 0);
    seen_valid = 0; seen_busy = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (if_a.valid) seen_valid++;
      if (if_a.busy) seen_busy++;
    end
    check("abort_no_valid", seen_valid, 0);
    check("abort_start_ignored", seen_busy, 0);
    check("abort_dout_held", if_a.dout, 7'h10);
    check("abort_trust_held", if_a.trustbit, 0);
    check("abort_chan_out_held", if_a.chan_out, 0);

    // Asynchronous reset in the middle of a conversion
    @(negedge clk);
    if_a.chan_sel = 2'd2; if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {if_a.busy, if_a.valid, if_a.trustbit, if_a.dout, if_a.chan_out, dac_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      if (if_a.valid || if_a.busy) seen_valid++;
    end
    check("midreset_no_activity", seen_valid, 0);

    run_conv(1'b0, 2'd3, 0, 7'h00, lat, d, t, co, va, ba);
    check("postreset_latency", lat, 9);
    check("postreset_dout", d, 7'h03);
    check("postreset_trust", t, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
